// File: rtl/axis_chk_pkg.sv
// Shared definitions for the AXI-stream packet checker: FSM state encoding,
// error-mask bit positions, header field positions and the legal
// last-beat keep test.
package axis_chk_pkg;

    typedef enum logic [1:0] {
        S_HDR     = 2'd0,
        S_PAYLOAD = 2'd1,
        S_DRAIN   = 2'd2
    } chk_state_e;

    localparam int ERR_MAGIC = 0;
    localparam int ERR_DATA  = 1;
    localparam int ERR_KEEP  = 2;
    localparam int ERR_LEN   = 3;
    localparam int ERR_SEQ   = 4;
    localparam int ERR_W     = 5;

    localparam int HDR_MAGIC_LSB = 48;
    localparam int HDR_SEQ_LSB   = 32;
    localparam int HDR_LEN_LSB   = 0;

    // A final beat may only enable a contiguous run of lanes starting at lane 0.
    function automatic logic keep_is_contig(input logic [7:0] keep);
        logic ok;
        case (keep)
            8'h01, 8'h03, 8'h07, 8'h0F,
            8'h1F, 8'h3F, 8'h7F, 8'hFF: ok = 1'b1;
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/axis_chk_if.sv
// 64-bit AXI-stream beat bundle (data/keep/last/valid/ready) feeding the checker.
interface axis_chk_if;
    logic [63:0] data_in;
    logic [7:0]  keep_in;
    logic        last_in;
    logic        valid_in;
    logic        ready_out;

    modport master (output data_in, keep_in, last_in, valid_in, input ready_out);
    modport slave  (input data_in, keep_in, last_in, valid_in, output ready_out);
endinterface

// File: rtl/axis_chk_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to throttle the sink's ready.
module axis_chk_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] o_state
);
    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign o_state = r_lfsr;

    // Reload the seed on reset, otherwise shift one step every cycle.
    always_ff @(posedge clk) begin
        if (reset) r_lfsr <= SEED;
        else       r_lfsr <= {r_lfsr[14:0], w_fb};
    end
endmodule

// File: rtl/axis_pkt_checker.sv
// AXI-stream packet checker: sinks every beat, validates header, payload
// pattern, keep and length, tracks sequence numbers and reports counters and
// sticky error flags. Optional ready throttling under AXIS_CHK_THROTTLE_EN.
module axis_pkt_checker
    import axis_chk_pkg::*;
#(
    parameter logic [15:0] MAGIC     = 16'hCAFE,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    axis_chk_if.slave        s_axis,
    output logic [31:0]      pkt_count,
    output logic [15:0]      err_count,
    output logic [ERR_W-1:0] err_flags,
    output logic             err_pulse
);
    localparam logic [1:0] ST_HDR     = S_HDR;
    localparam logic [1:0] ST_PAYLOAD = S_PAYLOAD;
    localparam logic [1:0] ST_DRAIN   = S_DRAIN;

    logic [1:0]       r_state;
    logic             r_armed;
    logic [15:0]      r_exp_seq;
    logic [7:0]       r_seq8;
    logic [15:0]      r_len;
    logic [15:0]      r_off;
    logic [16:0]      r_acc;
    logic [ERR_W-1:0] r_mask;
    logic [31:0]      r_pkt_count;
    logic [15:0]      r_err_count;
    logic [ERR_W-1:0] r_err_flags;
    logic             r_err_pulse;
    logic             r_ready;

    logic             w_accept;
    logic             w_in_hdr;
    logic [15:0]      w_hdr_magic;
    logic [15:0]      w_hdr_seq;
    logic [15:0]      w_hdr_len;
    logic [3:0]       w_keep_cnt;
    logic             w_data_err;
    logic [16:0]      w_acc_next;
    logic [ERR_W-1:0] w_hdr_mask;
    logic [ERR_W-1:0] w_pay_mask;
    logic [ERR_W-1:0] w_pkt_mask;

    assign w_accept    = s_axis.valid_in & r_ready;
    assign w_in_hdr    = (r_state != ST_PAYLOAD);
    assign w_hdr_magic = s_axis.data_in[HDR_MAGIC_LSB +: 16];
    assign w_hdr_seq   = s_axis.data_in[HDR_SEQ_LSB +: 16];
    assign w_hdr_len   = s_axis.data_in[HDR_LEN_LSB +: 16];
    assign w_acc_next  = r_acc + {13'd0, w_keep_cnt};

    // Per-lane payload compare against seq + offset + lane, plus enabled-lane count.
    always_comb begin
        w_keep_cnt = 4'd0;
        w_data_err = 1'b0;
        for (int k = 0; k < 8; k++) begin
            w_keep_cnt = w_keep_cnt + {3'd0, s_axis.keep_in[k]};
            if (s_axis.keep_in[k] &&
                (s_axis.data_in[8*k +: 8] != (r_seq8 + r_off[7:0] + 8'(k))))
                w_data_err = 1'b1;
        end
    end

    // Error mask contributed by the current beat, for header and payload views.
    always_comb begin
        w_hdr_mask            = '0;
        w_hdr_mask[ERR_MAGIC] = (w_hdr_magic != MAGIC);
        w_hdr_mask[ERR_KEEP]  = (s_axis.keep_in != 8'hFF);
        w_hdr_mask[ERR_SEQ]   = r_armed && (w_hdr_seq != r_exp_seq);
        w_hdr_mask[ERR_LEN]   = s_axis.last_in && (w_hdr_len != 16'd0);

        w_pay_mask            = '0;
        w_pay_mask[ERR_DATA]  = w_data_err;
        w_pay_mask[ERR_KEEP]  = s_axis.last_in ? !keep_is_contig(s_axis.keep_in)
                                               : (s_axis.keep_in != 8'hFF);
        w_pay_mask[ERR_LEN]   = s_axis.last_in && (w_acc_next != {1'b0, r_len});

        w_pkt_mask = w_in_hdr ? w_hdr_mask : (r_mask | w_pay_mask);
    end

    // Control: FSM, sequence arming, per-packet mask and completion reporting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_HDR;
            r_armed     <= 1'b0;
            r_mask      <= '0;
            r_pkt_count <= 32'd0;
            r_err_count <= 16'd0;
            r_err_flags <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    ST_PAYLOAD: begin
                        r_mask <= r_mask | w_pay_mask;
                        if (s_axis.last_in) r_state <= ST_HDR;
                    end
                    ST_HDR, ST_DRAIN: begin
                        r_armed <= 1'b1;
                        r_mask  <= w_hdr_mask;
                        r_state <= s_axis.last_in ? ST_HDR : ST_PAYLOAD;
                    end
                    default: r_state <= ST_HDR;
                endcase
                if (s_axis.last_in) begin
                    r_pkt_count <= r_pkt_count + 32'd1;
                    if (|w_pkt_mask) begin
                        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                        r_err_flags <= r_err_flags | w_pkt_mask;
                        r_err_pulse <= 1'b1;
                    end
                end
            end
        end
    end

    // Datapath: latch header fields, advance byte offset and length accumulator.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (w_in_hdr) begin
                r_exp_seq <= w_hdr_seq + 16'd1;
                r_seq8    <= w_hdr_seq[7:0];
                r_len     <= w_hdr_len;
                r_off     <= 16'd0;
                r_acc     <= 17'd0;
            end else begin
                r_off <= r_off + {12'd0, w_keep_cnt};
                r_acc <= w_acc_next;
            end
        end
    end

`ifdef AXIS_CHK_THROTTLE_EN
    logic [15:0] w_lfsr;

    axis_chk_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .o_state (w_lfsr)
    );

    // Registered ready from the LFSR's two low bits (~75% duty).
    always_ff @(posedge clk) begin
        if (reset) r_ready <= 1'b0;
        else       r_ready <= w_lfsr[1] | w_lfsr[0];
    end
`else
    localparam logic unused_seed = |LFSR_SEED;

    // Registered ready: low in reset, permanently high afterwards.
    always_ff @(posedge clk) begin
        if (reset) r_ready <= 1'b0;
        else       r_ready <= 1'b1;
    end
`endif

    assign s_axis.ready_out = r_ready;
    assign pkt_count        = r_pkt_count;
    assign err_count        = r_err_count;
    assign err_flags        = r_err_flags;
    assign err_pulse        = r_err_pulse;
endmodule

// File: tb/tb_axis_pkt_checker.sv
// Scoreboard bench for axis_pkt_checker: packet-level reference model,
// randomized packets with injected faults, decoupled completion monitor.
module tb_axis_pkt_checker;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pkt_count;
    logic [15:0] err_count;
    logic [4:0]  err_flags;
    logic        err_pulse;

    always #5 clk = ~clk;

    axis_chk_if bus ();

    axis_pkt_checker dut (
        .clk       (clk),
        .reset     (reset),
        .s_axis    (bus),
        .pkt_count (pkt_count),
        .err_count (err_count),
        .err_flags (err_flags),
        .err_pulse (err_pulse)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] ec;
        logic [4:0]  fl;
        logic        pl;
    } exp_t;
    exp_t sbq[$];

    int          m_pc = 0;
    int          m_ec = 0;
    logic [4:0]  m_fl = '0;
    bit          m_armed = 0;
    logic [15:0] m_exp = '0;

    logic [63:0] bd[$];
    logic [7:0]  bk[$];
    bit          bl[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic bit contig(logic [7:0] k);
        logic [7:0] k1;
        k1 = k + 8'd1;
        return (k != 8'd0) && ((k & k1) == 8'd0);
    endfunction

    task automatic model_reset();
        m_pc = 0; m_ec = 0; m_fl = '0; m_armed = 0;
    endtask

    // Evaluate the packet held in bd/bk/bl against the stream rules.
    task automatic model_pkt();
        logic [4:0]  m;
        logic [15:0] seq, len;
        int          b, n;
        exp_t        e;
        m   = '0;
        seq = bd[0][47:32];
        len = bd[0][15:0];
        if (bd[0][63:48] != 16'hCAFE) m[0] = 1'b1;
        if (bk[0] != 8'hFF) m[2] = 1'b1;
        if (m_armed && seq != m_exp) m[4] = 1'b1;
        m_exp = seq + 16'd1;
        m_armed = 1;
        if (bl[0]) begin
            if (len != 16'd0) m[3] = 1'b1;
        end else begin
            b = 0;
            n = bd.size();
            for (int i = 1; i < n; i++) begin
                for (int k = 0; k < 8; k++)
                    if (bk[i][k] && bd[i][8*k +: 8] != 8'(int'(seq[7:0]) + b + k)) m[1] = 1'b1;
                if (i < n - 1 && bk[i] != 8'hFF) m[2] = 1'b1;
                if (i == n - 1 && !contig(bk[i])) m[2] = 1'b1;
                b += $countones(bk[i]);
            end
            if ((b % 131072) != int'(len)) m[3] = 1'b1;
        end
        m_pc++;
        if (m != 0) begin
            if (m_ec < 65535) m_ec++;
            m_fl |= m;
        end
        e.pc = 32'(m_pc); e.ec = 16'(m_ec); e.fl = m_fl; e.pl = (m != 0);
        sbq.push_back(e);
    endtask

    // kinds: 0 clean, 1 data flip, 2 short non-last keep, 3 non-contig last keep,
    //        4 wrong len field, 5 bad magic, 6 bad header keep, 7 lane3 of beat1 = 00
    task automatic build_pkt(input logic [15:0] seq, input int len, input int kind);
        int nb, b, rem, bi;
        logic [7:0]  kp;
        logic [63:0] d, h;
        bd.delete(); bk.delete(); bl.delete();
        nb = (len + 7) / 8;
        h = {16'hCAFE, seq, 16'($urandom), 16'(len)};
        if (kind == 4) h[15:0] = 16'(len + 1);
        if (kind == 5) h[63:48] = 16'hCAFF;
        bd.push_back(h);
        bk.push_back(kind == 6 ? 8'h7F : 8'hFF);
        bl.push_back(nb == 0);
        b = 0;
        for (int i = 0; i < nb; i++) begin
            rem = len - 8 * i;
            kp = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
            if (kind == 2 && i == 0) kp = 8'h0F;
            if (kind == 3 && i == nb - 1) kp = 8'hA5;
            d = {$urandom, $urandom};
            for (int k = 0; k < 8; k++)
                if (kp[k]) d[8*k +: 8] = 8'(int'(seq[7:0]) + b + k);
            if (kind == 7 && i == 0) d[31:24] = 8'h00;
            b += $countones(kp);
            bd.push_back(d); bk.push_back(kp); bl.push_back(i == nb - 1);
        end
        if (kind == 1) begin
            bi = 1 + int'($urandom_range(nb - 1));
            bd[bi][7:0] = bd[bi][7:0] ^ 8'(1 + $urandom_range(254));
        end
    endtask

    // Present one beat from a negedge and hold it until it is accepted.
    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input bit l);
        logic rdy;
        int   n;
        n = 0;
        bus.data_in = d; bus.keep_in = k; bus.last_in = l; bus.valid_in = 1'b1;
        forever begin
            rdy = bus.ready_out;
            @(posedge clk);
            @(negedge clk);
            if (rdy) break;
            n++;
            if (n > 200) begin
                tests++; fails++;
                $display("FAIL ready_timeout: got ready=0 for %0d cycles expected 1", n);
                break;
            end
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic idle_gap();
        int g;
        g = int'($urandom_range(2));
        for (int i = 0; i < g; i++) begin
            bus.data_in = {$urandom, $urandom};
            bus.keep_in = 8'($urandom);
            bus.last_in = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [15:0] seq, input int len, input int kind);
        build_pkt(seq, len, kind);
        model_pkt();
        for (int i = 0; i < bd.size(); i++) begin
            drive_beat(bd[i], bk[i], bl[i]);
            idle_gap();
        end
    endtask

    task automatic pulse_reset();
        bus.valid_in = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // Monitor: on every completion pop the next expectation and compare.
    logic [31:0] seen = '0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            seen = '0;
        end else if (pkt_count != seen) begin
            seen = pkt_count;
            if (sbq.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_completion: got pkt_count=%0d expected no completion", pkt_count);
            end else begin
                e = sbq.pop_front();
                check("pkt_count", 64'(pkt_count), 64'(e.pc));
                check("err_count", 64'(err_count), 64'(e.ec));
                check("err_flags", 64'(err_flags), 64'(e.fl));
                check("err_pulse", 64'(err_pulse), 64'(e.pl));
            end
        end else begin
            check("idle_err_pulse", 64'(err_pulse), 64'd0);
        end
    end

    initial begin
        int len, kind;
        logic [15:0] seq;
        bus.data_in = '0; bus.keep_in = '0; bus.last_in = 1'b0; bus.valid_in = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.ready_out), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_err_flags", 64'(err_flags), 64'd0);
        check("rst_err_pulse", 64'(err_pulse), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(bus.ready_out), 64'd1);

        send(16'd0, 16, 0);
        send(16'd1, 5, 0);
        send(16'd2, 16, 7);
        send(16'd3, 16, 2);
        repeat (4) @(negedge clk);

        build_pkt(16'd4, 16, 0);
        drive_beat(bd[0], bk[0], bl[0]);
        pulse_reset();
        check("midrst_pkt_count", 64'(pkt_count), 64'd0);
        check("midrst_err_count", 64'(err_count), 64'd0);
        check("midrst_err_flags", 64'(err_flags), 64'd0);
        send(16'd7, 16, 0);
        repeat (4) @(negedge clk);

        pulse_reset();
        send(16'd0, 16, 0);
        send(16'd2, 9, 0);
        send(16'd3, 24, 0);
        repeat (4) @(negedge clk);

        for (int p = 0; p < 60; p++) begin
            len  = int'($urandom_range(40));
            kind = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(7));
            if (len == 0 && (kind == 1 || kind == 2 || kind == 3 || kind == 7)) kind = 0;
            if (len <= 8 && (kind == 2 || kind == 7)) kind = 0;
            seq = m_armed ? m_exp : 16'($urandom);
            if ($urandom_range(7) == 0) seq = seq + 16'(1 + $urandom_range(100));
            send(seq, len, kind);
        end

        repeat (20) @(negedge clk);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axis_pkt_checker.md
# axis_pkt_checker

Synthesizable AXI-stream packet checker on the output stream of the debug shell's packet path, consuming the 64-bit data/keep/last/valid/ready stream. It sinks every beat, checks the header and deterministic payload, counts packets and errors, and exposes sticky error flags for on-chip debug. It can also throttle `ready` to exercise upstream backpressure.

## Interface
- `MAGIC`, 16'hCAFE, required header tag
- `LFSR_SEED`, 16'hACE1, non-zero seed for the throttle LFSR (used only with the throttle macro)
- `clk`  in  1  sole clock
- `reset`  in  1  synchronous, active-high reset
- `data_in`  in  64  stream data; byte lane k is `data_in[8k+7:8k]`
- `keep_in`  in  8  byte enables
- `last_in`  in  1  end of packet
- `valid_in`  in  1  beat valid
- `ready_out`  out  1  beat accepted when `valid_in & ready_out`
- `pkt_count`  out  32  packets completed (good or bad)
- `err_count`  out  16  packets with at least one error; saturates at 16'hFFFF
- `err_flags`  out  5  sticky flags: [0] magic, [1] data, [2] keep, [3] length, [4] sequence
- `err_pulse`  out  1  one-cycle pulse when an errored packet completes

## Operation
- Header beat layout: `data[63:48]`=magic, `data[47:32]`=seq, `data[15:0]`=payload length in bytes. Header `keep` must be 8'hFF.
- Payload byte number i (0-based) must equal `(seq[7:0] + i) mod 256`. A beat at byte offset b is checked on each lane k with `keep[k]`=1 against `seq[7:0]+b+k` (8-bit wrap).
- Keep rule: non-last beats use 8'hFF. The last beat's keep is a contiguous run from lane 0: one of 01, 03, 07 … FF.
- Length rule: the sum of set keep bits over the payload beats equals `len`. A header with `last`=1 requires `len`=0.
- Sequence rule: the first packet after reset is accepted as-is. After that, `seq` must equal `exp_seq`. `exp_seq` is then set to `seq+1` (16-bit wrap) whether or not it matched, so the checker resyncs.
- States:
  - HDR: accept a beat and check magic, seq and keep, then latch `seq` and `len`. Go to PAYLOAD, or stay in HDR if `last`=1.
  - PAYLOAD: check data, keep and length on every beat. Go to HDR on `last`.
  - DRAIN: not used for recovery. Errors never stop consumption; checking continues to `last`.
- Errors found in a packet accumulate into a per-packet mask. When the packet completes (accepted `last`):
  - `pkt_count` increments.
  - If the mask is non-zero, `err_count` increments (saturating), the mask is ORed into `err_flags`, and `err_pulse` fires.
- Data arithmetic: the byte offset is a 16-bit counter. The length comparison uses a 17-bit accumulator, so overflow reads as a length error.

## Timing
- Reset values: `ready_out`=0, `pkt_count`=0, `err_count`=0, `err_flags`=0, `err_pulse`=0, state=HDR, seq tracker unarmed.
- `ready_out` is registered and rises the first cycle after `reset` deasserts. Without the throttle it then stays at 1.
- Counters, flags and `err_pulse` update on the edge after the cycle that accepts `last`, i.e. 1-cycle latency.
- No combinational path from inputs to `ready_out`.
- Beats with `valid_in`=0, or accepted while `ready_out`=0, change no state.
- Reset asserted mid-packet: the partial packet is discarded uncounted and the next accepted beat is treated as a header.
- `pkt_count` wraps at 2^32.

## Configuration
- `AXIS_CHK_THROTTLE_EN` defined: `ready_out` is driven by a 16-bit Fibonacci LFSR (taps 16,14,13,11) seeded with `LFSR_SEED` at reset. It advances every cycle, and `ready_out` = OR of LFSR bits [1:0], giving about 75% duty.
- Not defined: no LFSR is built, and `ready_out` is held at 1 after reset.

## Structure
- Package `axis_chk_pkg` holds:
  - the state enum (HDR, PAYLOAD, DRAIN)
  - error bit index constants (ERR_MAGIC=0 … ERR_SEQ=4)
  - the header field bit positions
  - the legal last-keep mask list function `keep_is_contig`
- Sub-module `axis_chk_lfsr`: 16-bit LFSR throttle, instantiated only under `AXIS_CHK_THROTTLE_EN`.

## Test plan
- Header CAFE/seq 0/len 16, then two FF beats carrying bytes 00..0F, `last` on the second → `pkt_count`=1, `err_count`=0, `err_flags`=0.
- Header seq 1/len 5, one beat of bytes 01..05 with keep 1F and `last` → passes; `pkt_count`=2, no `err_pulse`.
- Same as the first test but lane 3 of the first payload beat is 00 instead of 03 → `err_flags`=5'b00010, `err_count`=1, `err_pulse` high for one cycle after `last`.
- A non-last payload beat with keep 0F, then `last` with keep FF → `err_flags[2]` set and `err_flags[3]` set (length 12≠16).
- Packet seq 0, then seq 2, then seq 3, all with valid payloads → only the seq-2 packet flags `err_flags[4]`; `err_count`=1, `pkt_count`=3.
- `reset` pulsed one cycle after a header is accepted, then a clean seq-7 packet → counters 0 after reset; the seq-7 packet gives `pkt_count`=1 with no errors. With `AXIS_CHK_THROTTLE_EN`, the same stream completes with `ready_out` toggling.
